// File: rtl/rect_plotter.sv
// Rectangle walker for the VGA path: on go it scans a w x h box in raster order, one pixel per cycle.
// Optional macro RECT_PLOTTER_CLIP_EN gates plot to the visible SCREEN_W x SCREEN_H area.
module rect_plotter #(
    parameter int COORD_W  = 8,
    parameter int MAX_W    = 16,
    parameter int MAX_H    = 16,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         go,
    input  logic [COORD_W-1:0]           in_x,
    input  logic [COORD_W-1:0]           in_y,
    input  logic [$clog2(MAX_W+1)-1:0]   in_w,
    input  logic [$clog2(MAX_H+1)-1:0]   in_h,
    input  logic [COLOUR_W-1:0]          in_colour,
    input  logic                         in_mode,
    output logic [COORD_W-1:0]           x,
    output logic [COORD_W-1:0]           y,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         plot,
    output logic                         busy,
    output logic                         done
);
    localparam int WW  = $clog2(MAX_W + 1);
    localparam int HW  = $clog2(MAX_H + 1);
    localparam int CXW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int CYW = (MAX_H > 1) ? $clog2(MAX_H) : 1;

    localparam logic [WW-1:0] MAX_W_L = WW'(MAX_W);
    localparam logic [HW-1:0] MAX_H_L = HW'(MAX_H);
    localparam logic [COORD_W:0] SCR_W_L = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0] SCR_H_L = (COORD_W+1)'(SCREEN_H);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DRAW    = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]         state;
    logic [COORD_W-1:0] x0, y0;
    logic [WW-1:0]      w_q;
    logic [HW-1:0]      h_q;
    logic               mode_q;
    logic [CXW-1:0]     cx;
    logic [CYW-1:0]     cy;

    logic [WW-1:0]      w_sat;
    logic [HW-1:0]      h_sat;
    logic               col_end, last_pix;
    logic [CXW-1:0]     nxt_cx;
    logic [CYW-1:0]     nxt_cy;
    logic [COORD_W-1:0] sel_x0, sel_y0, nxt_x, nxt_y;
    logic [WW-1:0]      sel_w;
    logic [HW-1:0]      sel_h;
    logic               sel_mode, border, on_screen, nxt_plot;

    assign w_sat = (in_w > MAX_W_L) ? MAX_W_L : in_w;
    assign h_sat = (in_h > MAX_H_L) ? MAX_H_L : in_h;

    assign col_end  = (WW'(cx) == w_q - WW'(1));
    assign last_pix = col_end && (HW'(cy) == h_q - HW'(1));

    // In IDLE the first pixel is built straight from the request inputs so it
    // appears the cycle after go is accepted.
    always_comb begin
        nxt_cx   = '0;
        nxt_cy   = '0;
        sel_x0   = x0;
        sel_y0   = y0;
        sel_w    = w_q;
        sel_h    = h_q;
        sel_mode = mode_q;
        if (state == IDLE) begin
            sel_x0   = in_x;
            sel_y0   = in_y;
            sel_w    = w_sat;
            sel_h    = h_sat;
            sel_mode = in_mode;
        end else if (col_end) begin
            nxt_cy = cy + CYW'(1);
        end else begin
            nxt_cx = cx + CXW'(1);
            nxt_cy = cy;
        end
    end

    assign nxt_x  = sel_x0 + COORD_W'(nxt_cx);
    assign nxt_y  = sel_y0 + COORD_W'(nxt_cy);
    assign border = (nxt_cx == '0) || (WW'(nxt_cx) == sel_w - WW'(1)) ||
                    (nxt_cy == '0) || (HW'(nxt_cy) == sel_h - HW'(1));

`ifdef RECT_PLOTTER_CLIP_EN
    // One extra bit so a coordinate that overflows reads as off-screen.
    logic [COORD_W:0] sum_x, sum_y;
    assign sum_x     = {1'b0, sel_x0} + (COORD_W+1)'(nxt_cx);
    assign sum_y     = {1'b0, sel_y0} + (COORD_W+1)'(nxt_cy);
    assign on_screen = (sum_x < SCR_W_L) && (sum_y < SCR_H_L);
`else
    logic clip_unused;
    assign clip_unused = ^{SCR_W_L, SCR_H_L};
    assign on_screen   = 1'b1;
`endif

    assign nxt_plot = (!sel_mode || border) && on_screen;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= IDLE;
            x0     <= '0;
            y0     <= '0;
            w_q    <= '0;
            h_q    <= '0;
            mode_q <= 1'b0;
            cx     <= '0;
            cy     <= '0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        x0     <= in_x;
                        y0     <= in_y;
                        w_q    <= w_sat;
                        h_q    <= h_sat;
                        mode_q <= in_mode;
                        colour <= in_colour;
                        cx     <= '0;
                        cy     <= '0;
                        if (w_sat == '0 || h_sat == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            plot  <= 1'b0;
                        end else begin
                            state <= DRAW;
                            busy  <= 1'b1;
                            x     <= nxt_x;
                            y     <= nxt_y;
                            plot  <= nxt_plot;
                        end
                    end
                end
                DRAW: begin
                    if (last_pix) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        plot  <= 1'b0;
                    end else begin
                        cx   <= nxt_cx;
                        cy   <= nxt_cy;
                        x    <= nxt_x;
                        y    <= nxt_y;
                        plot <= nxt_plot;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= RELEASE;
                end
                default: begin
                    // A held go must drop before the next request is accepted.
                    if (!go) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rect_plotter.sv
// Directed self-checking bench for rect_plotter; expected pixels are computed from hand-written vectors.
module tb_rect_plotter;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       go;
    logic [7:0] in_x, in_y;
    logic [4:0] in_w, in_h;
    logic [2:0] in_colour;
    logic       in_mode;
    logic [7:0] x, y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // Observation word: {x, y, colour, plot, busy, done}
    logic [21:0] obs;
    assign obs = {x, y, colour, plot, busy, done};

    rect_plotter dut (
        .clock(clock), .reset_n(reset_n), .go(go),
        .in_x(in_x), .in_y(in_y), .in_w(in_w), .in_h(in_h),
        .in_colour(in_colour), .in_mode(in_mode),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int ix, input int iy, input int iw, input int ih,
                           input int icol, input int imode);
        in_x      = 8'(ix);
        in_y      = 8'(iy);
        in_w      = 5'(iw);
        in_h      = 5'(ih);
        in_colour = 3'(icol);
        in_mode   = 1'(imode);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        go = 1'b0;
        set_req(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        n_checks++;
        if (obs !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, 22'd0);
        end
        reset_n = 1'b1;
        step();
        n_checks++;
        if (obs !== 22'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h expected %h", obs, 22'd0);
        end
    endtask

    task automatic test_filled();
        logic [21:0] exp;
        repeat (2) step();
        set_req(10, 20, 4, 4, 5, 0);
        go = 1'b1;
        step();
        go = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                exp = {8'(10 + c), 8'(20 + r), 3'd5, 1'b1, 1'b1, 1'b0};
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL filled_pix r%0d c%0d: got %h expected %h", r, c, obs, exp);
                end
                step();
            end
        end
        exp = {8'd13, 8'd23, 3'd5, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL filled_done: got %h expected %h", obs, exp);
        end
        step();
        exp = {8'd13, 8'd23, 3'd5, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL filled_done_pulse_width: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_outline();
        logic [21:0] exp;
        logic        ep;
        repeat (2) step();
        set_req(0, 0, 4, 3, 2, 1);
        go = 1'b1;
        step();
        go = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                ep  = !(r == 1 && (c == 1 || c == 2));
                exp = {8'(c), 8'(r), 3'd2, ep, 1'b1, 1'b0};
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL outline_pix r%0d c%0d: got %h expected %h", r, c, obs, exp);
                end
                step();
            end
        end
        exp = {8'd3, 8'd2, 3'd2, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL outline_done: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_zero();
        logic [21:0] exp;
        repeat (2) step();
        set_req(50, 60, 0, 5, 6, 0);
        go = 1'b1;
        step();
        go = 1'b0;
        exp = {8'd3, 8'd2, 3'd6, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL zero_width_done: got %h expected %h", obs, exp);
        end
        step();
        exp = {8'd3, 8'd2, 3'd6, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL zero_width_after: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_saturation();
        logic [21:0] exp;
        repeat (2) step();
        set_req(100, 50, 31, 2, 1, 0);
        go = 1'b1;
        step();
        go = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 16; c++) begin
                exp = {8'(100 + c), 8'(50 + r), 3'd1, 1'b1, 1'b1, 1'b0};
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL sat_pix r%0d c%0d: got %h expected %h", r, c, obs, exp);
                end
                step();
            end
        end
        exp = {8'd115, 8'd51, 3'd1, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL sat_done: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] exp;
        repeat (2) step();
        set_req(5, 5, 2, 2, 3, 0);
        go = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            exp = {8'(5 + i % 2), 8'(5 + i / 2), 3'd3, 1'b1, 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL held_pix %0d: got %h expected %h", i, obs, exp);
            end
            step();
        end
        exp = {8'd6, 8'd6, 3'd3, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL held_done: got %h expected %h", obs, exp);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            exp = {8'd6, 8'd6, 3'd3, 1'b0, 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL held_no_retrigger %0d: got %h expected %h", i, obs, exp);
            end
        end
        go = 1'b0;
        step();
        set_req(40, 60, 1, 1, 4, 1);
        go = 1'b1;
        step();
        go = 1'b0;
        exp = {8'd40, 8'd60, 3'd4, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rearm_pix: got %h expected %h", obs, exp);
        end
        step();
        exp = {8'd40, 8'd60, 3'd4, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rearm_done: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] exp;
        repeat (2) step();
        set_req(10, 20, 4, 4, 7, 0);
        go = 1'b1;
        step();
        go = 1'b0;
        for (int i = 0; i < 7; i++) begin
            exp = {8'(10 + i % 4), 8'(20 + i / 4), 3'd7, 1'b1, 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL mid_pix %0d: got %h expected %h", i, obs, exp);
            end
            if (i < 6) step();
        end
        reset_n = 1'b0;
        step();
        n_checks++;
        if (obs !== 22'd0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got %h expected %h", obs, 22'd0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs !== 22'd0) begin
                n_fail++;
                $display("FAIL mid_reset_no_done %0d: got %h expected %h", i, obs, 22'd0);
            end
        end
        set_req(1, 2, 2, 1, 4, 0);
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 0; c < 2; c++) begin
            exp = {8'(1 + c), 8'd2, 3'd4, 1'b1, 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL post_reset_pix %0d: got %h expected %h", c, obs, exp);
            end
            step();
        end
        exp = {8'd2, 8'd2, 3'd4, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL post_reset_done: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_wrap_clip();
        logic [21:0] exp;
        logic        ep;
`ifdef RECT_PLOTTER_CLIP_EN
        ep = 1'b0;
`else
        ep = 1'b1;
`endif
        repeat (2) step();
        set_req(254, 7, 4, 1, 5, 0);
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 0; c < 4; c++) begin
            exp = {8'(254 + c), 8'd7, 3'd5, ep, 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL wrap_pix %0d: got %h expected %h", c, obs, exp);
            end
            step();
        end
        exp = {8'd1, 8'd7, 3'd5, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL wrap_done: got %h expected %h", obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_filled();
        test_outline();
        test_zero();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_wrap_clip();
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rect_plotter.md
Name: rect_plotter

Overview:
- Parametrised successor to the fixed-size block plotter in the VGA display path.
- On a go request it latches an origin (x, y), a size (w, h), a colour and a mode (filled or outline).
- It then walks the rectangle in raster order, emitting one pixel coordinate and colour per cycle, with a plot strobe for the VGA adapter.
- It has a busy/done handshake so the game controller can sequence several draws back to back.

Parameters:
- COORD_W, 8, width of the x/y coordinates and of the x/y outputs.
- MAX_W, 16, largest rectangle width in pixels; in_w values above this saturate to it.
- MAX_H, 16, largest rectangle height in pixels; in_h values above this saturate to it.
- COLOUR_W, 3, colour width.
- SCREEN_W, 160, visible width; used only when CLIP_EN is defined.
- SCREEN_H, 120, visible height; used only when CLIP_EN is defined.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  synchronous active-low reset
- go  input  1  draw request, level, sampled only in IDLE
- in_x  input  COORD_W  origin x (left column)
- in_y  input  COORD_W  origin y (top row)
- in_w  input  $clog2(MAX_W+1)  width in pixels
- in_h  input  $clog2(MAX_H+1)  height in pixels
- in_colour  input  COLOUR_W  pixel colour
- in_mode  input  1  0 = filled, 1 = outline only
- x  output  COORD_W  current pixel x
- y  output  COORD_W  current pixel y
- colour  output  COLOUR_W  latched colour
- plot  output  1  pixel write strobe for the current x/y
- busy  output  1  high from the cycle after go is accepted until done
- done  output  1  one-cycle pulse after the last scan cycle

Behaviour:
- Clock and reset: one clock, clock. Reset is synchronous and active-low on reset_n; it wins over every other input.
- Reset values: x=0, y=0, colour=0, plot=0, busy=0, done=0, state=IDLE, column and row counters=0.
- Reset mid-draw aborts immediately. No done pulse is issued.
- States: IDLE, DRAW, DONE, RELEASE.
- IDLE:
  - When go=1 at a rising edge, latch in_x, in_y, in_colour and in_mode.
  - Latch w=min(in_w,MAX_W) and h=min(in_h,MAX_H).
  - Clear the column and row counters (cx, cy) and go to DRAW.
  - If w=0 or h=0, go straight to DONE instead.
  - Inputs other than go are ignored outside IDLE.
- DRAW, one scan cycle per pixel:
  - x = x0+cx and y = y0+cy, both modulo 2^COORD_W, so coordinates wrap.
  - plot=1 in filled mode.
  - plot=1 in outline mode only when cx=0, cx=w-1, cy=0 or cy=h-1.
  - cx increments each cycle. At cx=w-1 it returns to 0 and cy increments.
  - After cx=w-1 with cy=h-1, go to DONE.
  - Total DRAW cycles = w*h exactly, in both modes.
- DONE: done=1 and busy=0 for exactly one cycle, plot=0. Go to RELEASE.
- RELEASE:
  - Wait for go=0, then go to IDLE.
  - A held go therefore never retriggers; a new draw needs go low for at least one cycle.
  - If go is already 0 in DONE, RELEASE lasts one cycle.
- Latency: go sampled at edge k gives the first DRAW cycle (first plot) at cycle k+1, with busy=1 from k+1.
- Between pixels: x and y hold their last values when not in DRAW; plot is registered with x, y and colour so all of them are aligned.
- Degenerate sizes: a 1x1 rectangle is a single plot. In outline mode, w=1 or h=1 plots every pixel. w=2 and h=2 plot all 4 pixels.
- Counter widths: cx is $clog2(MAX_W) bits, minimum 1. cy is $clog2(MAX_H) bits, minimum 1.

Optional Feature:
- Macro: RECT_PLOTTER_CLIP_EN.
- When defined:
  - plot is additionally gated by x0+cx < SCREEN_W and y0+cy < SCREEN_H.
  - These sums are computed in COORD_W+1 bits, so overflow counts as off-screen and no wrap-around pixel is plotted.
  - Scan cycle count is unchanged (still w*h).
- When undefined: no clipping; coordinates wrap modulo 2^COORD_W as described above.

Test Plan:
- Reset, then filled draw: go=1 for 1 cycle, in_x=10, in_y=20, w=4, h=4, colour=5, mode=0 -> 16 consecutive plot cycles covering (10..13, 20..23) in raster order, colour=5, then done for 1 cycle and busy=0.
- Outline: x=0, y=0, w=4, h=3, mode=1 -> 12 scan cycles. plot is high at the 10 border pixels and low at (1,1) and (2,1). One done pulse.
- Zero and saturation:
  - w=0, h=5 -> no plot, done on the cycle after go.
  - w=31 with MAX_W=16 -> 16 columns per row.
- Held go and re-arm: hold go=1 across the whole draw -> exactly one draw and no retrigger. Drop go for 1 cycle, then raise it -> a second draw starts 1 cycle after acceptance.
- Reset mid-operation: assert reset_n=0 at the 7th pixel of a 4x4 draw -> next cycle all outputs are 0 and there is no done. A new go afterwards draws normally.
- Wrap/clip: x=254, w=4, h=1:
  - Without RECT_PLOTTER_CLIP_EN -> plots at x=254, 255, 0, 1.
  - With RECT_PLOTTER_CLIP_EN -> no plot at all, since x ≥ 160, but still 4 scan cycles followed by done.
